// File: rtl/fnd_pkg.sv
// Shared constants for the FND display path: segment fonts, digit-enable idle
// pattern and the binary-to-BCD converter state encoding.
package fnd_pkg;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  localparam logic [3:0] COM_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  function automatic logic [7:0] font_of(input logic [3:0] nib);
    logic [7:0] f;
    case (nib)
      4'd0:    f = FONT_0;
      4'd1:    f = FONT_1;
      4'd2:    f = FONT_2;
      4'd3:    f = FONT_3;
      4'd4:    f = FONT_4;
      4'd5:    f = FONT_5;
      4'd6:    f = FONT_6;
      4'd7:    f = FONT_7;
      4'd8:    f = FONT_8;
      4'd9:    f = FONT_9;
      default: f = FONT_BLANK;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fnd_controller_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle in SHIFT,
// then a single DONE cycle during which bcd holds the finished result.
import fnd_pkg::*;

module bin2bcd_seq #(
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bcd
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  conv_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [11:0]       adj;

  // The thousands digit never reaches 5 before the final shift (max 8191),
  // so only the three lower nibbles need the add-3 correction.
  always_comb begin
    adj = bcd_q[11:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          shift_d = bin;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        bcd_d   = {bcd_q[14:12], adj, shift_q[DATA_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/fnd_controller.sv
// Adder-result display: captures {carry,sum}, converts to BCD and scans it
// onto a 4-digit common-anode 7-segment display.
import fnd_pkg::*;

module fnd_controller #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DATA_W      = 5,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic [3:0]        o_fnd_com,
  output logic [7:0]        o_fnd_font
);

  localparam int              DIV     = CLK_FREQ_HZ / SCAN_HZ;
  localparam int              CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic             conv_busy;
  logic             conv_done;
  logic [15:0]      conv_bcd;
  logic [15:0]      held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       font_q, font_d;
  logic             wrap;
  logic             blank;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (i_valid && !conv_busy),
    .bin     (i_data),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Fonts are decoded from the next-state value so a DONE landing on a scan
  // wrap lights the new digit with the new result on the very same edge.
  always_comb begin
    held_d = conv_done ? conv_bcd : held_q;
    wrap   = (cnt_q == CNT_MAX);
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    com_d  = ~(4'b0001 << idx_d);
    blank  = (BLANK_LZ != 0) && (idx_d != 2'd0) &&
             ((held_d >> {idx_d, 2'b00}) == 16'd0);
    font_d = blank ? FONT_BLANK : font_of(held_d[{idx_d, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      com_q  <= COM_OFF;
      font_q <= FONT_BLANK;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      com_q  <= com_d;
      font_q <= font_d;
    end
  end

  assign o_busy     = conv_busy;
  assign o_fnd_com  = com_q;
  assign o_fnd_font = font_q;

endmodule

// File: tb/tb_fnd_controller.sv
// Scoreboard bench for fnd_controller: two instances (5-bit blanking, 13-bit
// non-blanking) at 10 clocks per digit.
module tb_fnd_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid5 = 1'b0;
  logic [4:0]  data5 = '0;
  logic        busy5;
  logic [3:0]  com5;
  logic [7:0]  font5;
  logic        valid13 = 1'b0;
  logic [12:0] data13 = '0;
  logic        busy13;
  logic [3:0]  com13;
  logic [7:0]  font13;
  logic        use13 = 1'b0;
  logic        obs_busy;
  logic [3:0]  obs_com;
  logic [7:0]  obs_font;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_q[$];
  logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  fnd_controller #(.CLK_FREQ_HZ(100), .SCAN_HZ(10), .DATA_W(5), .BLANK_LZ(1)) dut5 (
    .clk(clk), .reset_n(reset_n), .i_valid(valid5), .i_data(data5),
    .o_busy(busy5), .o_fnd_com(com5), .o_fnd_font(font5)
  );

  fnd_controller #(.CLK_FREQ_HZ(100), .SCAN_HZ(10), .DATA_W(13), .BLANK_LZ(0)) dut13 (
    .clk(clk), .reset_n(reset_n), .i_valid(valid13), .i_data(data13),
    .o_busy(busy13), .o_fnd_com(com13), .o_fnd_font(font13)
  );

  always #5 clk = ~clk;

  // Bench-side cycle count since reset release, used to predict scan phase.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  assign obs_busy = use13 ? busy13 : busy5;
  assign obs_com  = use13 ? com13  : com5;
  assign obs_font = use13 ? font13 : font5;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] exp_font(input int v, input int d, input bit blank_lz);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (blank_lz && d > 0 && v < p) return 8'hFF;
    return font_tab[(v / p) % 10];
  endfunction

  function automatic int lit_index(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic send(input int v);
    if (use13) begin valid13 = 1'b1; data13 = 13'(v); end
    else       begin valid5  = 1'b1; data5  = 5'(v);  end
    exp_q.push_back(v);
    @(negedge clk);
    valid5  = 1'b0;
    valid13 = 1'b0;
  endtask

  task automatic wait_idle(input int exp_len, input string name);
    int n = 0;
    while (obs_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != exp_len) begin
      fails++;
      $display("[TB] FAIL %s: busy cycles got %0d expected %0d", name, n, exp_len);
    end
  endtask

  task automatic check_frame(input string name);
    int v;
    int n = 0;
    int k;
    bit seen [4] = '{default: 1'b0};
    logic [7:0] got [4] = '{default: 8'hxx};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s: scoreboard empty, got none expected one entry", name);
      return;
    end
    v = exp_q.pop_front();
    while (!(seen[0] && seen[1] && seen[2] && seen[3]) && n < 80) begin
      k = lit_index(obs_com);
      if (k >= 0) begin
        seen[k] = 1'b1;
        got[k]  = obs_font;
      end
      @(negedge clk);
      n++;
    end
    for (int d = 0; d < 4; d++) begin
      if (d > 0) tests++;
      if (!seen[d] || got[d] !== exp_font(v, d, !use13)) begin
        fails++;
        $display("[TB] FAIL %s digit%0d: got %h expected %h (value %0d)",
                 name, d, got[d], exp_font(v, d, !use13), v);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests += 4;
    if (com5 !== 4'b1111) begin fails++; $display("[TB] FAIL reset_com: got %b expected 1111", com5); end
    if (font5 !== 8'hFF) begin fails++; $display("[TB] FAIL reset_font: got %h expected ff", font5); end
    if (busy5 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy5: got %b expected 0", busy5); end
    if (busy13 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy13: got %b expected 0", busy13); end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_scan;
    int idx;
    logic [3:0] ec;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      idx = (cyc / 10) % 4;
      ec  = ~(4'b0001 << idx);
      tests += 2;
      if (com5 !== ec) begin
        fails++;
        $display("[TB] FAIL scan_com cyc%0d: got %b expected %b", cyc, com5, ec);
      end
      if (font5 !== exp_font(0, idx, 1'b1)) begin
        fails++;
        $display("[TB] FAIL scan_font cyc%0d: got %h expected %h", cyc, font5, exp_font(0, idx, 1'b1));
      end
    end
    tests++;
    if (busy5 !== 1'b0) begin fails++; $display("[TB] FAIL scan_busy: got %b expected 0", busy5); end
  endtask

  task automatic test_max;
    send(31);
    wait_idle(6, "busy_len_31");
    check_frame("frame_31");
  endtask

  task automatic test_drop;
    send(10);
    @(negedge clk);
    valid5 = 1'b1;
    data5  = 5'd7;
    @(negedge clk);
    valid5 = 1'b0;
    wait_idle(4, "busy_len_drop");
    check_frame("frame_drop");
  endtask

  task automatic test_back_to_back;
    int v;
    int k;
    send(3);
    wait_idle(6, "busy_len_b2b_a");
    v = exp_q.pop_front();
    k = lit_index(obs_com);
    tests++;
    if (k < 0 || obs_font !== exp_font(v, k, 1'b1)) begin
      fails++;
      $display("[TB] FAIL b2b_first: got %h expected %h", obs_font, exp_font(v, (k < 0) ? 0 : k, 1'b1));
    end
    send(20);
    wait_idle(6, "busy_len_b2b_b");
    check_frame("frame_b2b");
  endtask

  task automatic test_reset_mid;
    int hi = 0;
    send(25);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests += 3;
    if (com5 !== 4'b1111) begin fails++; $display("[TB] FAIL midrst_com: got %b expected 1111", com5); end
    if (font5 !== 8'hFF) begin fails++; $display("[TB] FAIL midrst_font: got %h expected ff", font5); end
    if (busy5 !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy5); end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy5 !== 1'b0) hi++;
    end
    tests++;
    if (hi != 0) begin fails++; $display("[TB] FAIL midrst_idle: busy cycles got %0d expected 0", hi); end
    exp_q.push_back(0);
    check_frame("frame_midrst");
  endtask

  task automatic test_align;
    int n = 0;
    while ((cyc % 40) != 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if ((cyc % 40) != 3) begin fails++; $display("[TB] FAIL align_phase: got %0d expected 3", cyc % 40); end
    send(12);
    repeat (5) @(negedge clk);
    tests += 2;
    if (com5 !== 4'b1110) begin fails++; $display("[TB] FAIL align_pre_com: got %b expected 1110", com5); end
    if (font5 !== 8'hC0) begin fails++; $display("[TB] FAIL align_pre_font: got %h expected c0", font5); end
    @(negedge clk);
    tests += 3;
    if (com5 !== 4'b1101) begin fails++; $display("[TB] FAIL align_post_com: got %b expected 1101", com5); end
    if (font5 !== 8'hF9) begin fails++; $display("[TB] FAIL align_post_font: got %h expected f9", font5); end
    if (busy5 !== 1'b0) begin fails++; $display("[TB] FAIL align_busy: got %b expected 0", busy5); end
    check_frame("frame_align");
  endtask

  task automatic test_wide;
    use13 = 1'b1;
    send(0);
    wait_idle(14, "busy_len_w0");
    check_frame("frame_w0");
    send(8191);
    wait_idle(14, "busy_len_w8191");
    check_frame("frame_w8191");
    use13 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_max();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_align();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
